// File: rtl/grf_wport_arb.sv
`default_nettype none
// ============================================================================
// Module   : grf_wport_arb
// Purpose  : Arbitrates the single GRF write port. In-order WB writes always
//            win. Auxiliary results (MDU, late loads) wait in a small FIFO
//            and fill idle write slots. The block exports a pending-register
//            mask and a WB-bubble request for when the queue starves.
// Revision : 1.0 - initial release
// ============================================================================
module grf_wport_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_wen,
  input  logic [4:0]  wb_wadd,
  input  logic [31:0] wb_wdat,
  input  logic [31:0] wb_pc,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_wadd,
  input  logic [31:0] aux_wdat,
  input  logic [31:0] aux_pc,
  output logic        GRFwen,
  output logic [4:0]  wadd,
  output logic [31:0] wdat,
  output logic [31:0] wpc,
  output logic        stall_req,
  output logic [31:0] busy_mask
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_SW   = $clog2(STARVE_MAX + 1);
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);
  localparam logic [c_SW-1:0] c_SMAX = c_SW'(STARVE_MAX);

  // FIFO storage; a slot is live while it still owes a GRF write
  logic [4:0]       r_ent_wadd [DEPTH];
  logic [31:0]      r_ent_wdat [DEPTH];
  logic [31:0]      r_ent_pc   [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [c_AW-1:0]  r_rd;
  logic [c_AW-1:0]  r_wr;
  logic [c_AW:0]    r_cnt;
  logic [c_SW-1:0]  r_st;
  logic             r_stall;
  logic [31:0]      r_busy;

  logic             w_wb_act;
  logic             w_full;
  logic             w_empty;
  logic             w_head_live;
  logic             w_head_dead;
  logic             w_grant_head;
  logic             w_pop;
  logic             w_push;
  logic [c_AW:0]    w_cnt_nxt;
  logic [c_SW-1:0]  w_st_nxt;
  logic [DEPTH-1:0] w_live_nxt;
  logic [31:0]      w_busy_nxt;

  assign w_wb_act     = wb_wen && (wb_wadd != 5'd0);
  assign w_full       = (r_cnt == c_FULL);
  assign w_empty      = (r_cnt == '0);
  assign w_head_live  = !w_empty && r_live[r_rd];
  assign w_head_dead  = !w_empty && !r_live[r_rd];
  assign w_grant_head = !w_wb_act && w_head_live;
  // A dead head leaves in parallel with a WB write; only one pop per cycle
  assign w_pop        = w_grant_head || w_head_dead;
  // Held low during reset so no producer handshakes against a cleared queue
  assign aux_ready    = rst_n && !w_full;
  // Writes to $0 are acknowledged but dropped
  assign w_push       = aux_valid && aux_ready && (aux_wadd != 5'd0);
  assign w_cnt_nxt    = r_cnt + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};

  // Next live vector (WAW kill, pop, push) and the pending mask it implies
  always_comb begin
    w_live_nxt = r_live;
    w_busy_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wb_act && r_live[i] && (r_ent_wadd[i] == wb_wadd))
        w_live_nxt[i] = 1'b0;
    end
    if (w_pop)
      w_live_nxt[r_rd] = 1'b0;
    // The slot being filled is empty, so a same-cycle WB write cannot kill it
    if (w_push)
      w_live_nxt[r_wr] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live_nxt[i]) begin
        if (w_push && (r_wr == c_AW'(i)))
          w_busy_nxt[aux_wadd] = 1'b1;
        else
          w_busy_nxt[r_ent_wadd[i]] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Starvation counter: counts WB wins over a live head, saturating
  always_comb begin
    w_st_nxt = r_st;
    if (w_grant_head || (w_cnt_nxt == '0))
      w_st_nxt = '0;
    else if (w_head_live && (r_st != c_SMAX))
      w_st_nxt = r_st + c_SW'(1);
  end

  // Write-port mux: WB first, then a live FIFO head, else idle zeros
  always_comb begin
    GRFwen = 1'b0;
    wadd   = 5'd0;
    wdat   = 32'd0;
    wpc    = 32'd0;
    if (w_wb_act) begin
      GRFwen = 1'b1;
      wadd   = wb_wadd;
      wdat   = wb_wdat;
      wpc    = wb_pc;
    end else if (w_head_live) begin
      GRFwen = 1'b1;
      wadd   = r_ent_wadd[r_rd];
      wdat   = r_ent_wdat[r_rd];
      wpc    = r_ent_pc[r_rd];
    end
  end

  // Queue state, pointers, starvation counter and registered exports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent_wadd[i] <= 5'd0;
        r_ent_wdat[i] <= 32'd0;
        r_ent_pc[i]   <= 32'd0;
      end
      r_live  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_st    <= '0;
      r_stall <= 1'b0;
      r_busy  <= 32'd0;
    end else begin
      if (w_push) begin
        r_ent_wadd[r_wr] <= aux_wadd;
        r_ent_wdat[r_wr] <= aux_wdat;
        r_ent_pc[r_wr]   <= aux_pc;
        r_wr             <= r_wr + c_AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + c_AW'(1);
      r_live  <= w_live_nxt;
      r_cnt   <= w_cnt_nxt;
      r_st    <= w_st_nxt;
      r_stall <= (w_st_nxt == c_SMAX);
      r_busy  <= w_busy_nxt;
    end
  end

  assign stall_req = r_stall;
  assign busy_mask = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_grf_wport_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_wport_arb
// Purpose  : Directed self-checking bench for grf_wport_arb (DEPTH=2,
//            STARVE_MAX=4) with a shadow register file built from observed
//            GRF writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_wport_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_wen;
  logic [4:0]  wb_wadd;
  logic [31:0] wb_wdat;
  logic [31:0] wb_pc;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_wadd;
  logic [31:0] aux_wdat;
  logic [31:0] aux_pc;
  logic        GRFwen;
  logic [4:0]  wadd;
  logic [31:0] wdat;
  logic [31:0] wpc;
  logic        stall_req;
  logic [31:0] busy_mask;

  int          n_chk = 0;
  int          n_bad = 0;
  int          n_wr  = 0;
  int          n_snap;
  logic [31:0] grf [32];

  grf_wport_arb #(.DEPTH(2), .STARVE_MAX(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_wen    (wb_wen),
    .wb_wadd   (wb_wadd),
    .wb_wdat   (wb_wdat),
    .wb_pc     (wb_pc),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_wadd  (aux_wadd),
    .aux_wdat  (aux_wdat),
    .aux_pc    (aux_pc),
    .GRFwen    (GRFwen),
    .wadd      (wadd),
    .wdat      (wdat),
    .wpc       (wpc),
    .stall_req (stall_req),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  // Shadow GRF: records every write the port commits
  always @(posedge clk) begin
    if (rst_n === 1'b1 && GRFwen === 1'b1) begin
      grf[wadd] = wdat;
      n_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wen  = en;
    wb_wadd = a;
    wb_wdat = d;
    wb_pc   = 32'h1000 + d;
  endtask

  task automatic set_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
    aux_valid = v;
    aux_wadd  = a;
    aux_wdat  = d;
    aux_pc    = 32'h2000 + d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) grf[i] = 32'd0;
    rst_n = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_aux(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("rst_ready", aux_ready, 0);
    chk("rst_wen",   GRFwen,    0);
    chk("rst_busy",  busy_mask, 0);
    chk("rst_stall", stall_req, 0);
    rst_n = 1'b1;

    // 1: WB pass-through in the same cycle
    set_wb(1'b1, 5'd5, 32'h1234);
    #1;
    chk("t1_wen",   GRFwen,    1);
    chk("t1_wadd",  wadd,      5);
    chk("t1_wdat",  wdat,      32'h1234);
    chk("t1_wpc",   wpc,       32'h2234);
    chk("t1_ready", aux_ready, 1);
    chk("t1_busy",  busy_mask, 0);
    tick();

    // 2: single aux result drains into an idle slot one cycle later
    set_wb(1'b0, 5'd0, 32'd0);
    set_aux(1'b1, 5'd8, 32'hAA);
    #1;
    chk("t2_nobypass", GRFwen, 0);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    #1;
    chk("t2_busy8", busy_mask, 32'h100);
    chk("t2_wen",   GRFwen,    1);
    chk("t2_wadd",  wadd,      8);
    chk("t2_wdat",  wdat,      32'hAA);
    chk("t2_wpc",   wpc,       32'h20AA);
    tick();
    chk("t2_busy0", busy_mask, 0);
    chk("t2_idle",  GRFwen,    0);

    // 3: two pushes under continuous WB traffic, starvation, then drain
    set_wb(1'b1, 5'd1, 32'h10);
    set_aux(1'b1, 5'd3, 32'h33);
    #1;
    chk("t3_ready0", aux_ready, 1);
    tick();
    set_wb(1'b1, 5'd2, 32'h11);
    set_aux(1'b1, 5'd4, 32'h44);
    #1;
    chk("t3_ready1", aux_ready, 1);
    chk("t3_wbwin",  wadd,      2);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd1, 32'h12);
    #1;
    chk("t3_full",  aux_ready, 0);
    chk("t3_busy",  busy_mask, 32'h18);
    chk("t3_st1",   stall_req, 0);
    tick();
    tick();
    chk("t3_st3",   stall_req, 0);
    tick();
    chk("t3_stall", stall_req, 1);
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("t3_r3_wen",  GRFwen, 1);
    chk("t3_r3_wadd", wadd,   3);
    chk("t3_r3_wdat", wdat,   32'h33);
    tick();
    chk("t3_stclr",   stall_req, 0);
    chk("t3_ready2",  aux_ready, 1);
    chk("t3_busy4",   busy_mask, 32'h10);
    set_wb(1'b1, 5'd1, 32'h13);
    tick();
    tick();
    tick();
    chk("t3_rst3",    stall_req, 0);
    tick();
    chk("t3_restall", stall_req, 1);
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("t3_r4_wadd", wadd, 4);
    chk("t3_r4_wdat", wdat, 32'h44);
    tick();
    chk("t3_st_end",  stall_req, 0);
    chk("t3_busyend", busy_mask, 0);
    chk("t3_grf3",    grf[3],    32'h33);
    chk("t3_grf4",    grf[4],    32'h44);

    // 4: WB write to the same register kills the queued entry
    n_snap = n_wr;
    set_aux(1'b1, 5'd9, 32'h11);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd9, 32'h22);
    #1;
    chk("t4_busy9", busy_mask, 32'h200);
    chk("t4_wdat",  wdat,      32'h22);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("t4_killed", busy_mask, 0);
    chk("t4_nowr",   GRFwen,    0);
    tick();
    chk("t4_idle",   GRFwen,    0);
    chk("t4_grf9",   grf[9],    32'h22);
    chk("t4_nwr",    n_wr - n_snap, 1);

    // 5: aux write to $0 is accepted and dropped
    n_snap = n_wr;
    set_aux(1'b1, 5'd0, 32'h55);
    #1;
    chk("t5_ready", aux_ready, 1);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    #1;
    chk("t5_busy", busy_mask, 0);
    chk("t5_wen",  GRFwen,    0);
    tick();
    chk("t5_wen2", GRFwen,    0);
    chk("t5_nwr",  n_wr - n_snap, 0);

    // 6: full and stalled, then an asynchronous reset mid-cycle
    set_wb(1'b1, 5'd1, 32'h20);
    set_aux(1'b1, 5'd10, 32'hA0);
    tick();
    set_aux(1'b1, 5'd11, 32'hB0);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    tick();
    chk("t6_stall", stall_req, 1);
    chk("t6_full",  aux_ready, 0);
    chk("t6_busy",  busy_mask, 32'hC00);
    #2;
    rst_n = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    n_snap = n_wr;
    #1;
    chk("t6_rst_stall", stall_req, 0);
    chk("t6_rst_busy",  busy_mask, 0);
    chk("t6_rst_ready", aux_ready, 0);
    chk("t6_rst_wen",   GRFwen,    0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_ready", aux_ready, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t6_nowen", GRFwen, 0);
      tick();
    end
    chk("t6_nwr",   n_wr - n_snap, 0);
    chk("t6_grf10", grf[10], 0);
    chk("t6_grf11", grf[11], 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
